// File: rtl/sys_timer_pkg.sv
// Shared definitions for the FF04-FF07 divider/timer block.
package sys_timer_pkg;

    // Register offsets within the FF04-FF07 window (CPU address bits [1:0])
    localparam logic [1:0] REG_DIV  = 2'b00;
    localparam logic [1:0] REG_TIMA = 2'b01;
    localparam logic [1:0] REG_TMA  = 2'b10;
    localparam logic [1:0] REG_TAC  = 2'b11;

    // Unimplemented TAC bits read back as ones
    localparam logic [7:0] TAC_READ_MASK = 8'hF8;

    typedef enum logic [1:0] {
        IDLE,
        OVF_WAIT,
        RELOAD
    } timer_state_t;

    // Divider bit that clocks TIMA for each TAC[1:0] rate select
    function automatic logic [3:0] tac_sel_bit(input logic [1:0] sel);
        case (sel)
            2'b00:   return 4'd9;
            2'b01:   return 4'd3;
            2'b10:   return 4'd5;
            default: return 4'd7;
        endcase
    endfunction

endpackage

// File: rtl/sys_timer_tick_sel.sv
// Selects the TAC-chosen divider tap and turns its falling edge into a TIMA
// increment strobe. Because the tap is gated by TAC[2] and muxed by TAC[1:0]
// before edge detection, DIV resets and TAC changes can also produce a strobe.
module timer_tick_sel
    import sys_timer_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DIV_WIDTH-1:0] i_div_cnt,
    input  logic [2:0]           i_tac,
    output logic                 o_tima_inc
);

    logic w_tick_src;
    logic r_tick_prev;

    // Gated divider tap selected by TAC
    always_comb begin
        w_tick_src = i_tac[2] & i_div_cnt[tac_sel_bit(i_tac[1:0])];
    end

    // Remember the previous tap value for falling-edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick_prev <= 1'b0;
        end else begin
            r_tick_prev <= w_tick_src;
        end
    end

    // Increment strobe on a 1 -> 0 transition of the gated tap
    always_comb begin
        o_tima_inc = r_tick_prev & ~w_tick_src;
    end

endmodule

// File: rtl/sys_timer.sv
// DIV/TIMA/TMA/TAC timer at FF04-FF07 with delayed TMA reload and a
// one-clock timer interrupt pulse.
module sys_timer
    import sys_timer_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned OVF_DELAY = 4
) (
    input  logic                 clk,
    input  logic                 nreset2,
    input  logic                 ff04_ff07,
    input  logic [1:0]           a,
    input  logic                 cpu_wr,
    input  logic                 cpu_rd,
    inout  wire  [7:0]           d,
    output logic                 int_timer,
    output logic [DIV_WIDTH-1:0] div_out
);

    // OVF_WAIT lasts OVF_DELAY-1 clocks and RELOAD one more, so TIMA reads
    // zero for OVF_DELAY clocks after the wrap.
    localparam int unsigned     CNT_W    = (OVF_DELAY > 2) ? $clog2(OVF_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(OVF_DELAY - 1);

    logic [DIV_WIDTH-1:0] r_div;
    logic [7:0]           r_tima;
    logic [7:0]           r_tma;
    logic [2:0]           r_tac;
    timer_state_t         r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_int;

    logic                 w_wr;
    logic                 w_rd;
    logic                 w_wr_div;
    logic                 w_wr_tima;
    logic                 w_wr_tma;
    logic                 w_wr_tac;
    logic                 w_tima_inc;
    logic [7:0]           w_rd_data;

    // Decoded register strobes
    always_comb begin
        w_wr      = ff04_ff07 & cpu_wr;
        w_rd      = ff04_ff07 & cpu_rd;
        w_wr_div  = w_wr & (a == REG_DIV);
        w_wr_tima = w_wr & (a == REG_TIMA);
        w_wr_tma  = w_wr & (a == REG_TMA);
        w_wr_tac  = w_wr & (a == REG_TAC);
    end

    // Free-running divider; a DIV write clears it instead of incrementing
    always_ff @(posedge clk or negedge nreset2) begin
        if (!nreset2) begin
            r_div <= '0;
        end else if (w_wr_div) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_WIDTH'(1);
        end
    end

    // TMA and TAC configuration registers
    always_ff @(posedge clk or negedge nreset2) begin
        if (!nreset2) begin
            r_tma <= '0;
            r_tac <= '0;
        end else begin
            if (w_wr_tma) r_tma <= d;
            if (w_wr_tac) r_tac <= d[2:0];
        end
    end

    timer_tick_sel #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick_sel (
        .i_clk      (clk),
        .i_rst_n    (nreset2),
        .i_div_cnt  (r_div),
        .i_tac      (r_tac),
        .o_tima_inc (w_tima_inc)
    );

    // TIMA counter with overflow wait, TMA reload and registered interrupt
    always_ff @(posedge clk or negedge nreset2) begin
        if (!nreset2) begin
            r_tima  <= '0;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_int   <= 1'b0;
        end else begin
            r_int <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_wr_tima) begin
                        r_tima <= d;
                    end else if (w_tima_inc) begin
                        if (r_tima == 8'hFF) begin
                            r_tima  <= '0;
                            r_cnt   <= CNT_INIT;
                            r_state <= OVF_WAIT;
                        end else begin
                            r_tima <= r_tima + 8'd1;
                        end
                    end
                end
                OVF_WAIT: begin
                    if (w_wr_tima) begin
                        r_tima  <= d;
                        r_state <= IDLE;
                    end else begin
                        if (w_tima_inc) r_tima <= r_tima + 8'd1;
                        if (r_cnt <= CNT_W'(1)) begin
                            r_state <= RELOAD;
                            r_int   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                RELOAD: begin
                    // A TMA write in this clock is forwarded straight into TIMA
                    r_tima  <= w_wr_tma ? d : r_tma;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // CPU read mux
    always_comb begin
        w_rd_data = '0;
        case (a)
            REG_DIV:  w_rd_data = r_div[15:8];
            REG_TIMA: w_rd_data = r_tima;
            REG_TMA:  w_rd_data = r_tma;
            default:  w_rd_data = TAC_READ_MASK | {5'b00000, r_tac};
        endcase
    end

    assign d         = w_rd ? w_rd_data : 8'hzz;
    assign int_timer = r_int;
    assign div_out   = r_div;

endmodule

// File: tb/tb_sys_timer.sv
// Self-checking bench for sys_timer: directed scenarios plus a randomized
// phase, all checked against a cycle-level behavioural model.
module tb_sys_timer;

    localparam int unsigned DIV_WIDTH = 16;
    localparam int unsigned OVF_DELAY = 4;

    logic        clk       = 1'b0;
    logic        nreset2   = 1'b0;
    logic        ff04_ff07 = 1'b0;
    logic [1:0]  a         = 2'b00;
    logic        cpu_wr    = 1'b0;
    logic        cpu_rd    = 1'b0;
    logic [7:0]  tb_d      = 8'h00;
    logic        tb_oe     = 1'b0;
    wire  [7:0]  d;
    logic        int_timer;
    logic [15:0] div_out;

    assign d = tb_oe ? tb_d : 8'hzz;

    sys_timer #(
        .DIV_WIDTH (DIV_WIDTH),
        .OVF_DELAY (OVF_DELAY)
    ) dut (
        .clk       (clk),
        .nreset2   (nreset2),
        .ff04_ff07 (ff04_ff07),
        .a         (a),
        .cpu_wr    (cpu_wr),
        .cpu_rd    (cpu_rd),
        .d         (d),
        .int_timer (int_timer),
        .div_out   (div_out)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state
    int unsigned m_div;
    int unsigned m_tima, m_tma, m_tac;
    bit          m_prev;
    int          m_pending;   // clocks left until reload completes; 1 = reload clock
    int          bitpos[4] = '{9, 3, 5, 7};

    logic [7:0]  last_rd;
    int          dut_int_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        m_div = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_prev = 0; m_pending = 0;
    endfunction

    function automatic logic [7:0] m_read(input logic [1:0] aa);
        case (aa)
            2'd0:    return 8'((m_div >> 8) & 255);
            2'd1:    return 8'(m_tima);
            2'd2:    return 8'(m_tma);
            default: return 8'(32'hF8 | m_tac);
        endcase
    endfunction

    function automatic void model_step(input bit wr, input logic [1:0] aa, input logic [7:0] data);
        bit src, inc, wd, wt, wm, wc;
        src = (m_tac >= 4) && (((m_div >> bitpos[m_tac & 3]) & 1) == 1);
        inc = m_prev && !src;
        wd  = wr && aa == 2'd0;
        wt  = wr && aa == 2'd1;
        wm  = wr && aa == 2'd2;
        wc  = wr && aa == 2'd3;
        if (m_pending == 1) begin
            m_tima    = wm ? data : m_tma;
            m_pending = 0;
        end else if (wt) begin
            m_tima    = data;
            m_pending = 0;
        end else if (inc) begin
            if (m_tima == 255 && m_pending == 0) begin
                m_tima    = 0;
                m_pending = OVF_DELAY;
            end else begin
                m_tima = (m_tima + 1) & 255;
                if (m_pending > 0) m_pending--;
            end
        end else if (m_pending > 0) begin
            m_pending--;
        end
        m_prev = src;
        m_div  = wd ? 0 : (m_div + 1) & 32'hFFFF;
        if (wm) m_tma = data;
        if (wc) m_tac = data & 7;
    endfunction

    // One clock: drive at posedge+1, check at negedge, advance the model.
    task automatic cycle(input bit sel, input bit wr, input bit rd,
                         input logic [1:0] aa, input logic [7:0] data);
        ff04_ff07 = sel; cpu_wr = wr; cpu_rd = rd; a = aa;
        tb_d = data; tb_oe = wr && !rd;
        @(negedge clk);
        check("div_out", 32'(div_out), m_div);
        check("int_timer", 32'(int_timer), 32'(m_pending == 1));
        if (int_timer === 1'b1) dut_int_cnt++;
        if (sel && rd) begin
            last_rd = d;
            check("read", 32'(d), 32'(m_read(aa)));
        end
        model_step(sel && wr, aa, data);
        @(posedge clk); #1;
        ff04_ff07 = 0; cpu_wr = 0; cpu_rd = 0; tb_oe = 0;
    endtask

    task automatic wr_reg(input logic [1:0] aa, input logic [7:0] data);
        cycle(1, 1, 0, aa, data);
    endtask

    task automatic rd_reg(input logic [1:0] aa);
        cycle(1, 0, 1, aa, 8'h00);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 2'd0, 8'h00);
    endtask

    // Bus must not be driven by the DUT: a bench-driven pattern reads back intact
    task automatic z_check(input bit sel, input bit rd, input string tag);
        ff04_ff07 = sel; cpu_rd = rd; cpu_wr = 0; a = 2'd3;
        tb_oe = 1; tb_d = 8'h00; #1;
        check(tag, 32'(d), 32'h00);
        tb_d = 8'hFF; #1;
        check(tag, 32'(d), 32'hFF);
        tb_oe = 0;
        idle();
    endtask

    task automatic do_reset();
        nreset2 = 0; #2;
        m_reset();
        check("rst_div", 32'(div_out), 32'h0);
        check("rst_int", 32'(int_timer), 32'h0);
        @(negedge clk);
        nreset2 = 1;
        model_step(0, 2'd0, 8'h00);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] v0, v1;
        int         ints_before;

        // 1: reset, DIV visible after 256 clocks, DIV write clears
        do_reset();
        for (int i = 0; i < 255; i++) idle();
        rd_reg(2'd0);
        check("t1_div_256", 32'(last_rd), 32'h01);
        wr_reg(2'd0, 8'h5A);
        rd_reg(2'd0);
        check("t1_div_clr", 32'(last_rd), 32'h00);

        // 2: TIMA counts at div bit 3 rate from div_cnt=0
        wr_reg(2'd3, 8'h00);
        wr_reg(2'd0, 8'h00);
        wr_reg(2'd1, 8'h00);
        wr_reg(2'd3, 8'h05);
        for (int i = 0; i < 300 && m_div != 161; i++) idle();
        rd_reg(2'd1);
        check("t2_tima_160", 32'(last_rd), 32'h0A);
        wr_reg(2'd3, 8'h04);
        idle(); idle();
        rd_reg(2'd1); v0 = last_rd;
        for (int i = 0; i < 1023; i++) idle();
        rd_reg(2'd1); v1 = last_rd;
        check("t2_rate1024", 32'(v1 - v0), 32'h01);

        // 3: overflow, 4 clocks of zero, reload from TMA, single interrupt
        wr_reg(2'd2, 8'hAB);
        wr_reg(2'd3, 8'h05);
        wr_reg(2'd1, 8'hFF);
        ints_before = dut_int_cnt;
        for (int i = 0; i < 40 && m_pending == 0; i++) rd_reg(2'd1);
        for (int i = 0; i < 4; i++) begin
            rd_reg(2'd1);
            check("t3_tima_zero", 32'(last_rd), 32'h00);
        end
        rd_reg(2'd1);
        check("t3_tima_reload", 32'(last_rd), 32'hAB);
        for (int i = 0; i < 5; i++) idle();
        check("t3_int_once", 32'(dut_int_cnt - ints_before), 32'd1);

        // 4: TIMA write in 2nd OVF_WAIT clock cancels reload and interrupt
        wr_reg(2'd1, 8'hFF);
        ints_before = dut_int_cnt;
        for (int i = 0; i < 40 && m_pending != OVF_DELAY - 1; i++) rd_reg(2'd1);
        wr_reg(2'd1, 8'h42);
        rd_reg(2'd1);
        check("t4_tima_42", 32'(last_rd), 32'h42);
        for (int i = 0; i < 10; i++) idle();
        check("t4_no_int", 32'(dut_int_cnt - ints_before), 32'd0);

        // Reload-clock collisions: TMA write forwards, TIMA write ignored
        wr_reg(2'd1, 8'hFF);
        for (int i = 0; i < 40 && m_pending != 1; i++) idle();
        check("reach_reload_a", 32'(int_timer), 32'h1);
        wr_reg(2'd2, 8'h37);
        rd_reg(2'd1);
        check("tma_wr_reload", 32'(last_rd), 32'h37);
        wr_reg(2'd1, 8'hFF);
        for (int i = 0; i < 40 && m_pending != 1; i++) idle();
        check("reach_reload_b", 32'(int_timer), 32'h1);
        wr_reg(2'd1, 8'h99);
        rd_reg(2'd1);
        check("tima_wr_reload", 32'(last_rd), 32'h37);

        // 5: DIV write while selected tap is high increments TIMA
        wr_reg(2'd0, 8'h00);
        for (int i = 0; i < 20 && m_div != 7; i++) idle();
        rd_reg(2'd1); v0 = last_rd;
        wr_reg(2'd0, 8'h00);
        idle();
        rd_reg(2'd1);
        check("t5_div_wr_inc", 32'(last_rd), 32'(v0 + 8'd1));
        for (int i = 0; i < 20 && m_div != 3; i++) idle();
        rd_reg(2'd1); v0 = last_rd;
        wr_reg(2'd0, 8'h00);
        idle();
        rd_reg(2'd1);
        check("t5_div_wr_noinc", 32'(last_rd), 32'(v0));

        // 6: TAC readback, bus release, reset mid-overflow
        wr_reg(2'd3, 8'h02);
        rd_reg(2'd3);
        check("t6_tac_read", 32'(last_rd), 32'hFA);
        z_check(0, 1, "t6_z_nosel");
        z_check(1, 0, "t6_z_nord");
        wr_reg(2'd2, 8'h77);
        wr_reg(2'd3, 8'h05);
        wr_reg(2'd1, 8'hFF);
        for (int i = 0; i < 40 && m_pending != OVF_DELAY - 1; i++) idle();
        ints_before = dut_int_cnt;
        do_reset();
        for (int i = 0; i < 8; i++) idle();
        check("t6_rst_no_int", 32'(dut_int_cnt - ints_before), 32'd0);
        rd_reg(2'd1);
        check("t6_rst_tima", 32'(last_rd), 32'h00);
        rd_reg(2'd2);
        check("t6_rst_tma", 32'(last_rd), 32'h00);
        rd_reg(2'd3);
        check("t6_rst_tac", 32'(last_rd), 32'hF8);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int unsigned r;
            logic [1:0]  ra;
            logic [7:0]  rdat;
            r    = $urandom_range(0, 99);
            ra   = 2'($urandom_range(0, 3));
            rdat = 8'($urandom);
            if (ra == 2'd1 && r[0]) rdat = 8'($urandom_range(8'hF8, 8'hFF));
            if (ra == 2'd0 && $urandom_range(0, 3) != 0) ra = 2'd1;
            if (r < 6)       cycle(1, 1, 0, ra, rdat);
            else if (r < 9)  cycle(0, 1, 0, ra, rdat);
            else if (r < 60) cycle(1, 0, 1, ra, 8'h00);
            else             idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
